// File: rtl/collector_pkg.sv
// Shared definitions for the verdict collector: beat tags, serializer
// states, the captured record layout and the default queue depth.
package collector_pkg;

  localparam int DEPTH_DEFAULT = 4;
  localparam int REC_W         = 194;

  localparam logic [1:0] TAG_TS   = 2'd0;
  localparam logic [1:0] TAG_OUT0 = 2'd1;
  localparam logic [1:0] TAG_OUT1 = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TS   = 2'd1,
    ST_OUT0 = 2'd2,
    ST_OUT1 = 2'd3
  } state_t;

  // One captured verdict: when it happened, which outputs were active and
  // both raw output values (only the masked ones are ever emitted).
  typedef struct packed {
    logic [63:0] ts;
    logic [1:0]  mask;
    logic [63:0] out0;
    logic [63:0] out1;
  } record_t;

endpackage

// File: rtl/verdict_collector_record_fifo.sv
// Synchronous record queue. Pointers carry one extra wrap bit so full and
// empty are distinguished without a separate counter. The storage itself is
// not reset; clearing the pointers is enough to discard its contents.
module record_fifo
  import collector_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  record_t din,
  input  logic    pop,
  output record_t dout,
  output logic    full,
  output logic    empty,
  output logic    last_one
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [REC_W-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [AW:0]      count;

  // Occupancy flags and next pointer values.
  always_comb begin
    count    = wr_q - rd_q;
    full     = (count == FULL_CNT);
    empty    = (count == '0);
    last_one = (count == PTR_ONE);
    wr_d     = push ? (wr_q + PTR_ONE) : wr_q;
    rd_d     = pop  ? (rd_q + PTR_ONE) : rd_q;
    dout     = record_t'(mem_q[rd_q[AW-1:0]]);
  end

  // Record storage; a push into a full queue that pops on the same edge
  // overwrites the slot being released, which is the intended behaviour.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q[AW-1:0]] <= REC_W'(din);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

endmodule

// File: rtl/verdict_collector.sv
// Timestamps monitor verdicts, queues them as records and serializes each
// record onto a valid/ready stream as a timestamp beat followed by the
// active output values, flagging and counting records lost to a full queue.
module verdict_collector
  import collector_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic signed [63:0] output_0,
  input  logic signed [63:0] output_1,
  input  logic               output_0_aktv,
  input  logic               output_1_aktv,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [63:0]        m_data,
  output logic [1:0]         m_tag,
  output logic               m_last,
  output logic               overflow,
  output logic [CNT_W-1:0]   drop_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [63:0]      ts_q, ts_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  record_t in_rec;
  record_t head;
  logic    capture, fire, pop, push, drop;
  logic    full, empty, last_one;

  record_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .din      (in_rec),
    .pop      (pop),
    .dout     (head),
    .full     (full),
    .empty    (empty),
    .last_one (last_one)
  );

  // Beat contents decoded from the current state and the head record; the
  // head only changes on a pop, so a stalled beat stays stable.
  always_comb begin
    m_valid = (state_q != ST_IDLE);
    m_data  = '0;
    m_tag   = TAG_TS;
    m_last  = 1'b0;
    case (state_q)
      ST_TS: begin
        m_data = head.ts;
      end
      ST_OUT0: begin
        m_data = head.out0;
        m_tag  = TAG_OUT0;
        m_last = !head.mask[1];
      end
      ST_OUT1: begin
        m_data = head.out1;
        m_tag  = TAG_OUT1;
        m_last = 1'b1;
      end
      default: ;
    endcase
  end

  // Capture, drop and serializer next-state decisions.
  always_comb begin
    capture = en && (output_0_aktv || output_1_aktv);
    fire    = m_valid && m_ready;
    pop     = fire && m_last;
    push    = capture && (!full || pop);
    drop    = capture && full && !pop;

    in_rec.ts   = ts_q;
    in_rec.mask = {output_1_aktv, output_0_aktv};
    in_rec.out0 = output_0;
    in_rec.out1 = output_1;

    ts_d       = en ? (ts_q + 64'd1) : ts_q;
    overflow_d = overflow_q || drop;
    drop_cnt_d = (drop && (drop_cnt_q != '1)) ? (drop_cnt_q + CNT_ONE) : drop_cnt_q;

    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!empty) state_d = ST_TS;
      end
      ST_TS: begin
        if (fire) state_d = head.mask[0] ? ST_OUT0 : ST_OUT1;
      end
      ST_OUT0: begin
        if (fire) begin
          if (head.mask[1])          state_d = ST_OUT1;
          else if (!last_one || push) state_d = ST_TS;
          else                        state_d = ST_IDLE;
        end
      end
      ST_OUT1: begin
        if (fire) state_d = (!last_one || push) ? ST_TS : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Serializer state, timestamp and overflow bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      ts_q       <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ts_q       <= ts_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_verdict_collector.sv
// Randomized bench for verdict_collector. A record-level model keeps the
// queue of expected beats, the timestamp and the drop bookkeeping, and every
// accepted beat plus the status outputs are compared against it each cycle.
module tb_verdict_collector;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic signed [63:0] output0;
  logic signed [63:0] output1;
  logic               output0Aktv;
  logic               output1Aktv;
  logic               mValid;
  logic               mReady;
  logic [63:0]        mData;
  logic [1:0]         mTag;
  logic               mLast;
  logic               overflowOut;
  logic [CNT_W-1:0]   dropCnt;

  typedef struct {
    logic [1:0]  tag;
    logic [63:0] data;
    logic        last;
  } beat_t;

  beat_t       expBeats[$];
  int          recCount;
  logic [63:0] modelTs;
  logic        modelOvf;
  int          modelDrops;
  bit          justFilled;
  int          totalChecks;
  int          badChecks;

  verdict_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .output_0      (output0),
    .output_1      (output1),
    .output_0_aktv (output0Aktv),
    .output_1_aktv (output1Aktv),
    .m_valid       (mValid),
    .m_ready       (mReady),
    .m_data        (mData),
    .m_tag         (mTag),
    .m_last        (mLast),
    .overflow      (overflowOut),
    .drop_cnt      (dropCnt)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clearModel();
    expBeats.delete();
    recCount   = 0;
    modelTs    = '0;
    modelOvf   = 1'b0;
    modelDrops = 0;
    justFilled = 1'b0;
  endtask

  // One cycle: drive inputs after the falling edge, then check the stream
  // and status against the model and advance the model across the next edge.
  task automatic applyStimulus(input logic e, input logic s0, input logic s1,
                               input logic [63:0] v0, input logic [63:0] v1,
                               input logic rdy);
    beat_t b;
    bit    popNow;
    bit    wasEmpty;
    bit    pushed;
    @(negedge clk);
    en          = e;
    output0Aktv = s0;
    output1Aktv = s1;
    output0     = v0;
    output1     = v1;
    mReady      = rdy;
    #1;
    checkOutput("m_valid", 64'(mValid), 64'((expBeats.size() > 0) && !justFilled));
    checkOutput("overflow", 64'(overflowOut), 64'(modelOvf));
    checkOutput("drop_cnt", 64'(dropCnt), 64'(modelDrops));
    wasEmpty = (expBeats.size() == 0);
    popNow   = 1'b0;
    pushed   = 1'b0;
    if (mValid && mReady) begin
      if (expBeats.size() == 0) begin
        checkOutput("unexpectedBeat", 64'd1, 64'd0);
      end else begin
        b = expBeats.pop_front();
        checkOutput("beatTag", 64'(mTag), 64'(b.tag));
        checkOutput("beatData", mData, b.data);
        checkOutput("beatLast", 64'(mLast), 64'(b.last));
        popNow = b.last;
      end
    end
    if (e && (s0 || s1)) begin
      if (recCount == DEPTH && !popNow) begin
        modelOvf = 1'b1;
        if (modelDrops < (2 ** CNT_W) - 1) modelDrops++;
      end else begin
        expBeats.push_back('{tag: 2'd0, data: modelTs, last: 1'b0});
        if (s0) expBeats.push_back('{tag: 2'd1, data: v0, last: !s1});
        if (s1) expBeats.push_back('{tag: 2'd2, data: v1, last: 1'b1});
        recCount++;
        pushed = 1'b1;
      end
    end
    if (popNow) recCount--;
    justFilled = wasEmpty && pushed;
    if (e) modelTs = modelTs + 64'd1;
  endtask

  task automatic randomCycle(input int readyPct, input int enPct);
    applyStimulus(($urandom_range(99) < enPct), 1'($urandom), 1'($urandom),
                  {$urandom, $urandom}, {$urandom, $urandom},
                  ($urandom_range(99) < readyPct));
  endtask

  task automatic idleCycles(input int n, input logic rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, rdy);
  endtask

  initial begin
    totalChecks = 0;
    badChecks   = 0;
    clearModel();
    rst         = 1'b0;
    en          = 1'b0;
    output0Aktv = 1'b0;
    output1Aktv = 1'b0;
    output0     = '0;
    output1     = '0;
    mReady      = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rstValid", 64'(mValid), 64'd0);
    checkOutput("rstLast", 64'(mLast), 64'd0);
    checkOutput("rstTag", 64'(mTag), 64'd0);
    checkOutput("rstData", mData, 64'd0);
    checkOutput("rstOverflow", 64'(overflowOut), 64'd0);
    checkOutput("rstDropCnt", 64'(dropCnt), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Single output_0 capture at timestamp 5.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 64'd7, 64'd0, 1'b1);
    idleCycles(4, 1'b1);

    // Both outputs, negative value carried bit-exact.
    applyStimulus(1'b1, 1'b1, 1'b1, -64'sd3, 64'sd9, 1'b1);
    idleCycles(5, 1'b1);

    // Stalled stream: six captures into a four-deep queue, then drain.
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b0, 64'(100 + i), '0, 1'b0);
    idleCycles(3, 1'b0);
    idleCycles(20, 1'b1);
    checkOutput("stallDrops", 64'(dropCnt), 64'd2);
    checkOutput("stallOverflow", 64'(overflowOut), 64'd1);

    // Disabled capture with toggling strobes; timestamp must stay frozen.
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b0, 1'($urandom), 1'($urandom), {$urandom, $urandom}, '0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, '0, 64'h1234, 1'b1);
    idleCycles(5, 1'b1);

    // Full queue with captures every cycle once the stream starts moving,
    // so last-beat handshakes coincide with pushes into a full queue.
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 1'b1, 1'b1, 64'(200 + i), 64'(300 + i), 1'b0);
    for (int i = 0; i < 12; i++)
      applyStimulus(1'b1, 1'b1, 1'b1, 64'(400 + i), 64'(500 + i), 1'b1);
    idleCycles(40, 1'b1);

    // Mixed random traffic at several backpressure levels.
    for (int i = 0; i < 600; i++) randomCycle(90, 60);
    for (int i = 0; i < 600; i++) randomCycle(40, 80);
    for (int i = 0; i < 600; i++) randomCycle(70, 30);
    for (int i = 0; i < 200 && expBeats.size() > 0; i++) idleCycles(1, 1'b1);

    // Reset between the TS and OUT0 beats of a record.
    applyStimulus(1'b1, 1'b1, 1'b0, 64'hdead, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    @(negedge clk);
    en     = 1'b0;
    mReady = 1'b0;
    rst    = 1'b0;
    #1;
    checkOutput("midRstValid", 64'(mValid), 64'd0);
    checkOutput("midRstDropCnt", 64'(dropCnt), 64'd0);
    clearModel();
    @(negedge clk);
    rst = 1'b1;
    idleCycles(10, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 64'd11, 64'd22, 1'b1);

    // Final drain with a bounded cycle budget.
    for (int i = 0; i < 200 && expBeats.size() > 0; i++) idleCycles(1, 1'b1);
    idleCycles(2, 1'b1);
    checkOutput("drainEmpty", 64'(expBeats.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/verdict_collector.md
VERDICT_COLLECTOR -- requirements
Module: verdict_collector

Interface
REQ-001 SHALL have parameter DEPTH, default 4, record FIFO depth; power of two, at least 2.
REQ-002 SHALL have parameter CNT_W, default 16, width of the drop counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port en, input, 1, capture and timestamp enable.
REQ-006 SHALL have ports output_0 and output_1, input, 64 each, signed monitor output values.
REQ-007 SHALL have ports output_0_aktv and output_1_aktv, input, 1 each, output-active strobes.
REQ-008 SHALL have port m_valid, output, 1, stream beat valid.
REQ-009 SHALL have port m_ready, input, 1, downstream accepts beat.
REQ-010 SHALL have port m_data, output, 64, beat payload.
REQ-011 SHALL have port m_tag, output, 2, beat type: 0 = timestamp, 1 = output_0, 2 = output_1.
REQ-012 SHALL have port m_last, output, 1, final beat of a record.
REQ-013 SHALL have port overflow, output, 1, sticky flag: a record was dropped.
REQ-014 SHALL have port drop_cnt, output, CNT_W, number of dropped records.

Function
REQ-015 SHALL keep a 64-bit timestamp counter that increments by 1 each cycle en=1, holds when en=0, and wraps from 2^64-1 to 0.
REQ-016 In a cycle where en=1 and either aktv strobe is 1, SHALL push one record {timestamp, mask={output_1_aktv,output_0_aktv}, output_0, output_1} into the FIFO.
REQ-017 SHALL capture nothing when en=0; the serializer keeps draining.
REQ-018 SHALL use the timestamp value held before the same-edge increment; the first enabled cycle after reset records 0.
REQ-019 If the FIFO is full and no record completes on the same edge, SHALL drop the incoming record, set overflow, and increment drop_cnt, saturating at all-ones.
REQ-020 If the FIFO is full and the last beat of the head record is accepted on the same edge, SHALL accept the push without a drop.
REQ-021 Serializer FSM states: IDLE, TS, OUT0, OUT1.
REQ-022 IDLE -> TS when the FIFO is non-empty; the FSM advances only on an m_valid && m_ready handshake.
REQ-023 TS emits the timestamp; next state is OUT0 if mask[0], else OUT1.
REQ-024 OUT0 emits output_0; next state is OUT1 if mask[1], else the record ends.
REQ-025 OUT1 emits output_1; the record then ends.
REQ-026 At record end, SHALL pop the FIFO, then go to TS if it is non-empty, else IDLE; there is no idle bubble between records.
REQ-027 SHALL assert m_last with the final beat of every record, so each record is 2 or 3 beats.
REQ-028 m_valid SHALL be asserted in TS, OUT0 and OUT1.
REQ-029 While m_valid=1 and m_ready=0, m_data, m_tag and m_last SHALL hold stable.
REQ-030 Latency: a record captured at edge N drives its TS beat from edge N+1 when the FIFO was empty and the FSM was IDLE.
REQ-031 m_data SHALL carry signed values bit-exact, with no extension or truncation.

Reset
REQ-032 On rst=0, SHALL asynchronously clear the timestamp, FIFO pointers, overflow and drop_cnt, set the FSM to IDLE, and drive m_valid=0, m_last=0, m_tag=0, m_data=0.
REQ-033 Reset mid-record SHALL discard the partial record and all queued records; no beat is emitted after release until a new capture.

Structure
REQ-034 SHALL place the tag constants, FSM state encoding, record width (194 bits) and the DEPTH default in a shared package, collector_pkg.
REQ-035 SHALL instantiate one sub-module, record_fifo: a synchronous FIFO with push, pop, full and empty, using the same clk and rst.

Verification
REQ-036 Reset release, en=1, output_0_aktv=1 with output_0=7 at timestamp 5, m_ready=1 -> beats (tag0,5),(tag1,7,last).
REQ-037 Both strobes, output_0=-3, output_1=9, m_ready=1 -> beats (tag0,ts),(tag1,-3),(tag2,9,last); -3 appears as 0xFFFF_FFFF_FFFF_FFFD.
REQ-038 m_ready=0 and 6 consecutive single-output captures, DEPTH=4 -> overflow=1, drop_cnt=2; after m_ready=1, exactly 4 records drain in order.
REQ-039 en=0 for 10 cycles while strobes toggle -> no records; the timestamp resumes from its frozen value.
REQ-040 Pulse rst=0 mid-record, between the TS and OUT0 beats -> m_valid=0 immediately, drop_cnt=0, no leftover beats.
REQ-041 FIFO full, and a last-beat handshake coincides with a new capture -> no drop; the new record is emitted after the three queued ones.
